// File: rtl/custom_pkg.sv
// Pipeline hazard-unit control bundle shared by the stage modules.
package custom_pkg;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic flush_id;
        logic flush_ex;
    } hazard_t;

endpackage

// File: rtl/riscv_pkg.sv
// RV32I encoding constants and the decode-to-execute control bundle.
package riscv_pkg;

    typedef logic [31:0] instr_t;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Sltu   = 3'b011;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3SrlSra = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
    } alu_op_e;

    typedef enum logic [1:0] {SrcARs1, SrcAPc, SrcAZero} alu_src_a_e;
    typedef enum logic [0:0] {SrcBRs2, SrcBImm} alu_src_b_e;
    typedef enum logic [1:0] {ResAlu, ResMem, ResPc4} result_src_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        alu_src_a_e  alu_src_a;
        alu_src_b_e  alu_src_b;
        alu_op_e     alu_op;
        result_src_e result_src;
        logic [2:0]  funct3;
    } ctrl_t;

    // alt selects SUB/SRA; callers decide when bit 30 is meaningful.
    function automatic alu_op_e alu_op_from_f3(logic [2:0] f3, logic alt);
        case (f3)
            F3AddSub: alu_op_from_f3 = alt ? AluSub : AluAdd;
            F3Sll:    alu_op_from_f3 = AluSll;
            F3Slt:    alu_op_from_f3 = AluSlt;
            F3Sltu:   alu_op_from_f3 = AluSltu;
            F3Xor:    alu_op_from_f3 = AluXor;
            F3SrlSra: alu_op_from_f3 = alt ? AluSra : AluSrl;
            F3Or:     alu_op_from_f3 = AluOr;
            default:  alu_op_from_f3 = AluAnd;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// Integer register file: two combinational reads, one synchronous write, x0 hardwired to zero.
// DECODE_RF_BYPASS_EN makes reads write-through from the writeback port.
module regfile #(
    parameter int unsigned RegCount = 32
) (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    logic [31:0] mem_q [RegCount];

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i != 5'd0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef DECODE_RF_BYPASS_EN
    logic hit1, hit2;
    assign hit1 = we_i && (waddr_i != 5'd0) && (waddr_i == raddr1_i);
    assign hit2 = we_i && (waddr_i != 5'd0) && (waddr_i == raddr2_i);

    always_comb begin
        rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : (hit1 ? wdata_i : mem_q[raddr1_i]);
        rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : (hit2 ? wdata_i : mem_q[raddr2_i]);
    end
`else
    always_comb begin
        rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : mem_q[raddr1_i];
        rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : mem_q[raddr2_i];
    end
`endif

endmodule

// File: rtl/decode.sv
// RV32I decode stage: control/immediate generation, register read and the ID/EX register.
// Register-file bypass is enabled by DECODE_RF_BYPASS_EN.
module decode
    import riscv_pkg::*;
    import custom_pkg::*;
#(
    parameter int unsigned RegCount = 32
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  hazard_t     hazard_i,
    input  instr_t      instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic [4:0]  rs1_id_o,
    output logic [4:0]  rs2_id_o,
    output ctrl_t       ctrl_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        illegal_o
);

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rdata1, rdata2;
    ctrl_t       ctrl_d;
    logic [31:0] imm_d;
    logic        illegal_d;
    logic        unused_hazard;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7   = instr_i[31:25];
    assign rs1_id_o = instr_i[19:15];
    assign rs2_id_o = instr_i[24:20];

    assign unused_hazard = ^{hazard_i.stall_if, hazard_i.stall_id, hazard_i.flush_id};

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[30:21], 1'b0};

    regfile #(
        .RegCount (RegCount)
    ) u_regfile (
        .clk_i    (clk_i),
        .we_i     (wb_we_i),
        .waddr_i  (wb_rd_i),
        .wdata_i  (wb_data_i),
        .raddr1_i (rs1_id_o),
        .raddr2_i (rs2_id_o),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    always_comb begin
        ctrl_d    = '0;
        imm_d     = 32'd0;
        illegal_d = 1'b0;
        case (opcode)
            OpcLui: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src_a = SrcAZero;
                ctrl_d.alu_src_b = SrcBImm;
                imm_d            = imm_u;
            end
            OpcAuipc: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src_a = SrcAPc;
                ctrl_d.alu_src_b = SrcBImm;
                imm_d            = imm_u;
            end
            OpcJal: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                ctrl_d.alu_src_a  = SrcAPc;
                ctrl_d.alu_src_b  = SrcBImm;
                ctrl_d.result_src = ResPc4;
                imm_d             = imm_j;
            end
            OpcJalr: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                ctrl_d.alu_src_b  = SrcBImm;
                ctrl_d.result_src = ResPc4;
                ctrl_d.funct3     = funct3;
                imm_d             = imm_i;
                illegal_d         = (funct3 != 3'b000);
            end
            OpcBranch: begin
                ctrl_d.branch = 1'b1;
                ctrl_d.alu_op = AluSub;
                ctrl_d.funct3 = funct3;
                imm_d         = imm_b;
                illegal_d     = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OpcLoad: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.alu_src_b  = SrcBImm;
                ctrl_d.result_src = ResMem;
                ctrl_d.funct3     = funct3;
                imm_d             = imm_i;
                illegal_d         = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                                    (funct3 == 3'b111);
            end
            OpcStore: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src_b = SrcBImm;
                ctrl_d.funct3    = funct3;
                imm_d            = imm_s;
                illegal_d        = (funct3 > 3'b010);
            end
            OpcOpImm: begin
                // Only shifts carry a funct7; ADDI with bit 30 set is still ADDI.
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src_b = SrcBImm;
                ctrl_d.alu_op    = alu_op_from_f3(funct3, (funct3 == F3SrlSra) && funct7[5]);
                ctrl_d.funct3    = funct3;
                imm_d            = imm_i;
                if (funct3 == F3Sll) begin
                    illegal_d = (funct7 != F7Base);
                end else if (funct3 == F3SrlSra) begin
                    illegal_d = (funct7 != F7Base) && (funct7 != F7Alt);
                end
            end
            OpcOp: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = alu_op_from_f3(funct3, funct7[5]);
                ctrl_d.funct3    = funct3;
                if (funct7 == F7Alt) begin
                    illegal_d = (funct3 != F3AddSub) && (funct3 != F3SrlSra);
                end else begin
                    illegal_d = (funct7 != F7Base);
                end
            end
            default: illegal_d = |instr_i;  // all-zero word is a fetch bubble
        endcase
        if (illegal_d) begin
            ctrl_d = '0;
        end
    end

    // Reset and flush both leave a clean bubble in ID/EX.
    always_ff @(posedge clk_i) begin
        if (!rstn_i || hazard_i.flush_ex) begin
            ctrl_o     <= '0;
            rs1_data_o <= 32'd0;
            rs2_data_o <= 32'd0;
            imm_o      <= 32'd0;
            pc_o       <= 32'd0;
            pc_plus4_o <= 32'd0;
            rs1_o      <= 5'd0;
            rs2_o      <= 5'd0;
            rd_o       <= 5'd0;
            illegal_o  <= 1'b0;
        end else begin
            ctrl_o     <= ctrl_d;
            rs1_data_o <= rdata1;
            rs2_data_o <= rdata2;
            imm_o      <= imm_d;
            pc_o       <= pc_i;
            pc_plus4_o <= pc_plus4_i;
            rs1_o      <= rs1_id_o;
            rs2_o      <= rs2_id_o;
            rd_o       <= instr_i[11:7];
            illegal_o  <= illegal_d;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed vector bench for the decode stage, with register-file and reset sequences.
module tb_decode;
    import riscv_pkg::*;
    import custom_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    hazard_t     hazard;
    instr_t      instr;
    logic [31:0] pc, pc4;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1_id, rs2_id, rs1, rs2, rd;
    ctrl_t       ctrl;
    logic [31:0] rs1_data, rs2_data, imm, pc_out, pc4_out;
    logic        illegal;

    always #5 clk = ~clk;

    decode #(
        .RegCount (32)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .hazard_i   (hazard),
        .instr_i    (instr),
        .pc_i       (pc),
        .pc_plus4_i (pc4),
        .wb_we_i    (wb_we),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .rs1_id_o   (rs1_id),
        .rs2_id_o   (rs2_id),
        .ctrl_o     (ctrl),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .imm_o      (imm),
        .pc_o       (pc_out),
        .pc_plus4_o (pc4_out),
        .rs1_o      (rs1),
        .rs2_o      (rs2),
        .rd_o       (rd),
        .illegal_o  (illegal)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic ctrl_t mk(logic rw, logic mr, logic mw, logic br, logic jp,
                                 alu_src_a_e a, alu_src_b_e b, alu_op_e op,
                                 result_src_e res, logic [2:0] f3);
        ctrl_t c;
        c.reg_write  = rw;
        c.mem_read   = mr;
        c.mem_write  = mw;
        c.branch     = br;
        c.jump       = jp;
        c.alu_src_a  = a;
        c.alu_src_b  = b;
        c.alu_op     = op;
        c.result_src = res;
        c.funct3     = f3;
        return c;
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic        flush;
        ctrl_t       ctrl;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    initial begin
        ctrl_t nop;
        nop = '0;
        vecs[0]  = '{32'hFFF00093, 1'b0,
                     mk(1, 0, 0, 0, 0, SrcARs1, SrcBImm, AluAdd, ResAlu, 3'd0),
                     32'hFFFFFFFF, 5'd1, 1'b0};  // addi x1,x0,-1
        vecs[1]  = '{32'hFE000EE3, 1'b0,
                     mk(0, 0, 0, 1, 0, SrcARs1, SrcBRs2, AluSub, ResAlu, 3'd0),
                     32'hFFFFFFFC, 5'd29, 1'b0}; // beq x0,x0,-4
        vecs[2]  = '{32'h123451B7, 1'b0,
                     mk(1, 0, 0, 0, 0, SrcAZero, SrcBImm, AluAdd, ResAlu, 3'd0),
                     32'h12345000, 5'd3, 1'b0};  // lui x3,0x12345
        vecs[3]  = '{32'h008000EF, 1'b0,
                     mk(1, 0, 0, 0, 1, SrcAPc, SrcBImm, AluAdd, ResPc4, 3'd0),
                     32'h00000008, 5'd1, 1'b0};  // jal x1,+8
        vecs[4]  = '{32'h0020A623, 1'b0,
                     mk(0, 0, 1, 0, 0, SrcARs1, SrcBImm, AluAdd, ResAlu, 3'd2),
                     32'h0000000C, 5'd12, 1'b0}; // sw x2,12(x1)
        vecs[5]  = '{32'hFF80A203, 1'b0,
                     mk(1, 1, 0, 0, 0, SrcARs1, SrcBImm, AluAdd, ResMem, 3'd2),
                     32'hFFFFFFF8, 5'd4, 1'b0};  // lw x4,-8(x1)
        vecs[6]  = '{32'h40335293, 1'b0,
                     mk(1, 0, 0, 0, 0, SrcARs1, SrcBImm, AluSra, ResAlu, 3'd5),
                     32'h00000403, 5'd5, 1'b0};  // srai x5,x6,3
        vecs[7]  = '{32'h402083B3, 1'b0,
                     mk(1, 0, 0, 0, 0, SrcARs1, SrcBRs2, AluSub, ResAlu, 3'd0),
                     32'h00000000, 5'd7, 1'b0};  // sub x7,x1,x2
        vecs[8]  = '{32'h00001517, 1'b0,
                     mk(1, 0, 0, 0, 0, SrcAPc, SrcBImm, AluAdd, ResAlu, 3'd0),
                     32'h00001000, 5'd10, 1'b0}; // auipc x10,1
        vecs[9]  = '{32'h004100E7, 1'b0,
                     mk(1, 0, 0, 0, 1, SrcARs1, SrcBImm, AluAdd, ResPc4, 3'd0),
                     32'h00000004, 5'd1, 1'b0};  // jalr x1,4(x2)
        vecs[10] = '{32'h0000007F, 1'b0, nop, 32'h0, 5'd0, 1'b1}; // unknown opcode
        vecs[11] = '{32'h40001033, 1'b0, nop, 32'h0, 5'd0, 1'b1}; // OP alt funct7 + SLL
        vecs[12] = '{32'h00002063, 1'b0, nop, 32'h0, 5'd0, 1'b1}; // branch funct3 010
        vecs[13] = '{32'h00000000, 1'b0, nop, 32'h0, 5'd0, 1'b0}; // fetch bubble
        vecs[14] = '{32'h0020A623, 1'b1, nop, 32'h0, 5'd0, 1'b0}; // sw under flush_ex

        rstn    = 1'b0;
        hazard  = '0;
        instr   = 32'hFFF00093;
        pc      = 32'h0000_0040;
        pc4     = 32'h0000_0044;
        wb_we   = 1'b0;
        wb_rd   = 5'd0;
        wb_data = 32'd0;
        tick;
        tick;
        chk("reset ctrl", 32'(ctrl), 32'h0);
        chk("reset imm", imm, 32'h0);
        chk("reset pc", pc_out, 32'h0);
        chk("reset rd", {27'd0, rd}, 32'h0);
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            instr         = vecs[i].instr;
            hazard.flush_ex = vecs[i].flush;
            pc            = 32'h1000 + 32'(i) * 4;
            pc4           = pc + 32'd4;
            tick;
            chk($sformatf("v%0d ctrl", i), 32'(ctrl), 32'(vecs[i].ctrl));
            chk($sformatf("v%0d imm", i), imm, vecs[i].imm);
            chk($sformatf("v%0d rd", i), {27'd0, rd}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
            chk($sformatf("v%0d pc", i), pc_out, vecs[i].flush ? 32'h0 : pc);
            chk($sformatf("v%0d pc4", i), pc4_out, vecs[i].flush ? 32'h0 : pc + 32'd4);
        end
        hazard = '0;

        // WB -> ID on x5, same cycle as the read.
        instr   = 32'h0;
        wb_we   = 1'b1;
        wb_rd   = 5'd5;
        wb_data = 32'h0BAD_F00D;
        tick;
        wb_data = 32'h1234_5678;
        instr   = 32'h00028433;  // add x8,x5,x0
        #1;
        chk("rs1_id comb", {27'd0, rs1_id}, 32'd5);
        chk("rs2_id comb", {27'd0, rs2_id}, 32'd0);
        tick;
`ifdef DECODE_RF_BYPASS_EN
        chk("x5 same-cycle", rs1_data, 32'h1234_5678);
`else
        chk("x5 same-cycle", rs1_data, 32'h0BAD_F00D);
`endif
        chk("rs1_o", {27'd0, rs1}, 32'd5);
        chk("rd_o add", {27'd0, rd}, 32'd8);
        wb_we = 1'b0;
        tick;
        chk("x5 later", rs1_data, 32'h1234_5678);

        // rs2 port.
        wb_we   = 1'b1;
        wb_rd   = 5'd6;
        wb_data = 32'hA5A5_A5A5;
        instr   = 32'h0;
        tick;
        wb_we = 1'b0;
        instr = 32'h006004B3;  // add x9,x0,x6
        tick;
        chk("x6 rs2", rs2_data, 32'hA5A5_A5A5);
        chk("x0 rs1", rs1_data, 32'h0);
        chk("rs2_o", {27'd0, rs2}, 32'd6);

        // Writes to x0 must vanish, including a concurrent one.
        wb_we   = 1'b1;
        wb_rd   = 5'd0;
        wb_data = 32'hDEAD_BEEF;
        instr   = 32'h0;
        tick;
        instr = 32'h00000133;  // add x2,x0,x0
        tick;
        chk("x0 rs1 after wr", rs1_data, 32'h0);
        chk("x0 rs2 after wr", rs2_data, 32'h0);
        wb_we = 1'b0;

        // Reset mid-stream clears ID/EX but not the register file.
        instr = 32'h008000EF;
        pc    = 32'h2000;
        pc4   = 32'h2004;
        tick;
        chk("pre-reset rd", {27'd0, rd}, 32'd1);
        rstn = 1'b0;
        tick;
        chk("mid reset ctrl", 32'(ctrl), 32'h0);
        chk("mid reset imm", imm, 32'h0);
        chk("mid reset rd", {27'd0, rd}, 32'h0);
        chk("mid reset pc", pc_out, 32'h0);
        chk("mid reset pc4", pc4_out, 32'h0);
        chk("mid reset illegal", {31'd0, illegal}, 32'h0);
        rstn  = 1'b1;
        instr = 32'h00028433;
        tick;
        chk("x5 after reset", rs1_data, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
